ps2_event_tx: RTL and testbench

//  Parametrised PS/2 device-side transmitter for DESim benches and on-board self-test; successor to the single-code keyboard stub.

---
 rtl/ps2_event_tx.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_event_tx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_event_tx.sv
// PS/2 device-side transmitter: queues key events, expands them to [E0] [F0] code
// and serialises each byte as an 11-bit frame, backing off while the host inhibits.
module ps2_event_tx #(
    parameter int DEPTH = 8,
    parameter int HALF  = 2000,
    parameter int GAP   = 4000
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   ev_valid,
    output logic                   ev_ready,
    input  logic                   ev_break,
    input  logic                   ev_ext,
    input  logic [7:0]             ev_code,
    input  logic                   host_clk_i,
    output logic                   ps2_clk_o,
    output logic                   ps2_dat_o,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (HALF > GAP) ? HALF : GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HALF_LD = TW'(HALF - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, LOW, GAP_WAIT, INHIBIT} state_t;
    state_t state;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic          sync1, sync2, inhibit;
    logic [TW-1:0] tcnt;
    logic [3:0]    bitn, nbit;
    logic [1:0]    idx, last;
    logic          fin;
    logic [7:0]    bytes [3];
    logic [7:0]    cur;
    logic [10:0]   frame;
    logic [9:0]    head;

    // Handshake: an event transfers on any rising edge with ev_valid & ev_ready. ev_ready is
    // also high in LOAD, because that edge pops a slot, so a full FIFO can take a push then.
    assign pop      = (state == LOAD);
    assign ev_ready = (fifo_count != CW'(DEPTH)) || pop;
    assign push     = ev_valid && ev_ready;
    assign busy     = (state != IDLE) || (fifo_count != '0);
    assign inhibit  = !sync2 && ps2_clk_o;
    assign head     = mem[rd_ptr];
    assign cur      = bytes[idx];
    assign frame    = {1'b1, ~^cur, cur, 1'b0};
    assign nbit     = bitn + 4'd1;

    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_ptr] <= {ev_break, ev_ext, ev_code};
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            sync1      <= 1'b1;
            sync2      <= 1'b1;
        end else begin
            sync1 <= host_clk_i;
            sync2 <= sync1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (pop && !push) fifo_count <= fifo_count - CW'(1);
            if (ev_valid && !ev_ready) overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            ps2_clk_o <= 1'b1;
            ps2_dat_o <= 1'b1;
            tcnt      <= '0;
            bitn      <= '0;
            idx       <= '0;
            last      <= '0;
            fin       <= 1'b0;
            bytes[0]  <= '0;
            bytes[1]  <= '0;
            bytes[2]  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_count != '0 && !inhibit) state <= LOAD;
                end
                LOAD: begin
                    case (head[9:8])   // {break, ext}
                        2'b00: begin
                            bytes[0] <= head[7:0];
                            last     <= 2'd0;
                        end
                        2'b01: begin
                            bytes[0] <= 8'hE0;
                            bytes[1] <= head[7:0];
                            last     <= 2'd1;
                        end
                        2'b10: begin
                            bytes[0] <= 8'hF0;
                            bytes[1] <= head[7:0];
                            last     <= 2'd1;
                        end
                        default: begin
                            bytes[0] <= 8'hE0;
                            bytes[1] <= 8'hF0;
                            bytes[2] <= head[7:0];
                            last     <= 2'd2;
                        end
                    endcase
                    idx       <= '0;
                    bitn      <= '0;
                    fin       <= 1'b0;
                    tcnt      <= HALF_LD;
                    ps2_dat_o <= 1'b0;
                    state     <= SETUP;
                end
                SETUP: begin
                    if (inhibit) begin
                        ps2_dat_o <= 1'b1;
                        bitn      <= '0;
                        tcnt      <= GAP_LD;
                        state     <= INHIBIT;
                    end else if (tcnt == '0) begin
                        ps2_clk_o <= 1'b0;
                        tcnt      <= HALF_LD;
                        state     <= LOW;
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                LOW: begin
                    if (tcnt == '0) begin
                        ps2_clk_o <= 1'b1;
                        if (bitn != 4'd10) begin
                            bitn      <= nbit;
                            ps2_dat_o <= frame[nbit];
                            tcnt      <= HALF_LD;
                            state     <= SETUP;
                        end else begin
                            ps2_dat_o <= 1'b1;
                            tcnt      <= GAP_LD;
                            state     <= GAP_WAIT;
                        end
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                GAP_WAIT: begin
                    // The byte just sent is complete, so an inhibit here resumes with the next one.
                    if (inhibit) begin
                        bitn  <= '0;
                        tcnt  <= GAP_LD;
                        state <= INHIBIT;
                        if (idx != last) idx <= idx + 2'd1;
                        else             fin <= 1'b1;
                    end else if (tcnt == '0) begin
                        if (idx != last) begin
                            idx       <= idx + 2'd1;
                            bitn      <= '0;
                            ps2_dat_o <= 1'b0;
                            tcnt      <= HALF_LD;
                            state     <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                INHIBIT: begin
                    if (inhibit) begin
                        tcnt <= GAP_LD;
                    end else if (tcnt == '0) begin
                        if (fin) begin
                            state <= IDLE;
                        end else begin
                            ps2_dat_o <= 1'b0;
                            tcnt      <= HALF_LD;
                            state     <= SETUP;
                        end
                    end else begin
                        tcnt <= tcnt - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_event_tx.sv
// Bench for ps2_event_tx: decodes the emitted PS/2 frames and compares them with
// byte sequences derived from the pushed events.
module tb_ps2_event_tx;
    localparam int DEPTH = 8;
    localparam int HALF  = 6;
    localparam int GAP   = 10;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLOCK_50 = 1'b0;
    logic          resetn = 1'b0;
    logic          ev_valid = 1'b0;
    logic          ev_break = 1'b0;
    logic          ev_ext = 1'b0;
    logic [7:0]    ev_code = 8'h00;
    logic          host_clk_i = 1'b1;
    logic          ev_ready, ps2_clk_o, ps2_dat_o, busy, overflow;
    logic [CW-1:0] fifo_count;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_event_tx #(.DEPTH(DEPTH), .HALF(HALF), .GAP(GAP)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_break(ev_break), .ev_ext(ev_ext), .ev_code(ev_code), .host_clk_i(host_clk_i),
        .ps2_clk_o(ps2_clk_o), .ps2_dat_o(ps2_dat_o), .busy(busy),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    typedef struct packed {
        logic [7:0]  b;
        logic        p;
        logic [31:0] t;
    } rx_t;

    typedef struct packed {
        logic        brk;
        logic        ext;
        logic [7:0]  code;
        logic [1:0]  n;
        logic [23:0] b;
        logic [2:0]  p;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    rx_t         rx_q[$];
    logic [7:0]  exp_q[$];
    vec_t        vecs[6];
    vec_t        v;
    rx_t         r;
    rx_t         tmp;
    logic [31:0] t_prev;
    int          cyc = 0, last_fall = 0, fstart = 0, bitcnt = 0, partial_cnt = 0, fall_cnt = 0;
    int          pbase, fbase, lows, n;
    logic        prev_clk = 1'b1;
    logic        frame_bad = 1'b0;
    logic [10:0] bits = '0;
    logic        rb, re;
    logic [7:0]  rc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame decoder: one record per complete 11-bit frame; a long pause mid-frame discards it.
    always @(negedge CLOCK_50) begin
        cyc = cyc + 1;
        if (!resetn) begin
            bitcnt   = 0;
            prev_clk = 1'b1;
        end else begin
            if (prev_clk && !ps2_clk_o) begin
                fall_cnt++;
                if (bitcnt != 0 && (cyc - last_fall) != 2 * HALF) begin
                    if ((cyc - last_fall) > 2 * HALF) begin
                        partial_cnt++;
                        bitcnt = 0;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
                if (bitcnt == 0) begin
                    frame_bad = 1'b0;
                    fstart    = cyc;
                end
                bits[bitcnt] = ps2_dat_o;
                bitcnt++;
                last_fall = cyc;
                if (bitcnt == 11) begin
                    tests++;
                    if (bits[0] !== 1'b0 || bits[10] !== 1'b1 || bits[9] !== ~^bits[8:1] || frame_bad) begin
                        fails++;
                        $display("FAIL frame_format: got frame %03h timing_bad=%0d, required start 0, odd parity, stop 1, %0d-cycle bit period",
                                 bits, frame_bad, 2 * HALF);
                    end
                    tmp.b = bits[8:1];
                    tmp.p = bits[9];
                    tmp.t = fstart;
                    rx_q.push_back(tmp);
                    bitcnt = 0;
                end
            end
            prev_clk = ps2_clk_o;
        end
    end

    task automatic drive_ev(input logic brk, input logic ext, input logic [7:0] code);
        ev_break = brk;
        ev_ext   = ext;
        ev_code  = code;
        ev_valid = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic drive_idle();
        ev_valid = 1'b0;
    endtask

    task automatic model_push(input logic brk, input logic ext, input logic [7:0] code);
        if (ext) exp_q.push_back(8'hE0);
        if (brk) exp_q.push_back(8'hF0);
        exp_q.push_back(code);
    endtask

    task automatic wait_cycles(input int cnt);
        repeat (cnt) @(negedge CLOCK_50);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge CLOCK_50);
            k++;
        end
        check(name, {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_ready(input string name, input int budget);
        int k;
        k = 0;
        while (!ev_ready && k < budget) begin
            @(negedge CLOCK_50);
            k++;
        end
        check(name, {31'b0, ev_ready}, 32'd1);
    endtask

    task automatic wait_fall(input string name, input int budget);
        int   k;
        logic p;
        logic seen;
        k    = 0;
        seen = 1'b0;
        p    = ps2_clk_o;
        while (!seen && k < budget) begin
            @(negedge CLOCK_50);
            k++;
            if (p && !ps2_clk_o) seen = 1'b1;
            p = ps2_clk_o;
        end
        check(name, {31'b0, seen}, 32'd1);
    endtask

    task automatic check_stream(input string name);
        rx_t        q;
        logic [7:0] e;
        check({name, "_len"}, rx_q.size(), exp_q.size());
        while (rx_q.size() != 0 && exp_q.size() != 0) begin
            q = rx_q.pop_front();
            e = exp_q.pop_front();
            check({name, "_byte"}, {24'b0, q.b}, {24'b0, e});
            check({name, "_par"}, {31'b0, q.p}, {31'b0, ~^e});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{brk: 1'b0, ext: 1'b0, code: 8'h1C, n: 2'd1, b: 24'h00001C, p: 3'b000};
        vecs[1] = '{brk: 1'b1, ext: 1'b1, code: 8'h75, n: 2'd3, b: 24'h75F0E0, p: 3'b010};
        vecs[2] = '{brk: 1'b1, ext: 1'b0, code: 8'h12, n: 2'd2, b: 24'h0012F0, p: 3'b011};
        vecs[3] = '{brk: 1'b0, ext: 1'b1, code: 8'h6B, n: 2'd2, b: 24'h006BE0, p: 3'b000};
        vecs[4] = '{brk: 1'b0, ext: 1'b0, code: 8'hFF, n: 2'd1, b: 24'h0000FF, p: 3'b001};
        vecs[5] = '{brk: 1'b0, ext: 1'b0, code: 8'h00, n: 2'd1, b: 24'h000000, p: 3'b001};

        // Clock/reset
        resetn = 1'b0;
        wait_cycles(4);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        check("reset_clk", {31'b0, ps2_clk_o}, 32'd1);
        check("reset_dat", {31'b0, ps2_dat_o}, 32'd1);
        check("reset_ready", {31'b0, ev_ready}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_count", {{(32-CW){1'b0}}, fifo_count}, 32'd0);
        check("reset_overflow", {31'b0, overflow}, 32'd0);

        // Single events: expected byte lists, parities and byte spacing from the table
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            drive_ev(v.brk, v.ext, v.code);
            drive_idle();
            wait_idle("vec_idle", 2000);
            check("vec_nbytes", rx_q.size(), {30'b0, v.n});
            for (int j = 0; j < int'(v.n) && rx_q.size() != 0; j++) begin
                r = rx_q.pop_front();
                check("vec_byte", {24'b0, r.b}, {24'b0, v.b[j*8 +: 8]});
                check("vec_parity", {31'b0, r.p}, {31'b0, v.p[j]});
                if (j > 0) check("vec_byte_spacing", r.t - t_prev, 22 * HALF + GAP);
                t_prev = r.t;
            end
            rx_q.delete();
        end

        // Push and pop on the same edge while full
        model_push(1'b0, 1'b0, 8'h21);
        drive_ev(1'b0, 1'b0, 8'h21);
        drive_idle();
        wait_cycles(4);
        for (int i = 0; i < DEPTH; i++) begin
            model_push(1'b0, 1'b0, 8'(8'h30 + i));
            drive_ev(1'b0, 1'b0, 8'(8'h30 + i));
        end
        drive_idle();
        check("full_count", {{(32-CW){1'b0}}, fifo_count}, DEPTH);
        check("full_ready", {31'b0, ev_ready}, 32'd0);
        wait_ready("pop_ready", 1000);
        check("pop_count_before", {{(32-CW){1'b0}}, fifo_count}, DEPTH);
        model_push(1'b0, 1'b0, 8'h40);
        drive_ev(1'b0, 1'b0, 8'h40);
        drive_idle();
        check("pushpop_count", {{(32-CW){1'b0}}, fifo_count}, DEPTH);
        check("pushpop_overflow", {31'b0, overflow}, 32'd0);
        wait_idle("pushpop_idle", 4000);
        check_stream("pushpop");

        // Overflow: DEPTH+1 pushes while a frame is active
        model_push(1'b0, 1'b0, 8'h50);
        drive_ev(1'b0, 1'b0, 8'h50);
        drive_idle();
        wait_cycles(4);
        for (int i = 0; i < DEPTH; i++) begin
            model_push(1'b0, 1'b0, 8'(8'h51 + i));
            drive_ev(1'b0, 1'b0, 8'(8'h51 + i));
        end
        check("ovf_ready_low", {31'b0, ev_ready}, 32'd0);
        check("ovf_count_full", {{(32-CW){1'b0}}, fifo_count}, DEPTH);
        check("ovf_before", {31'b0, overflow}, 32'd0);
        drive_ev(1'b0, 1'b0, 8'h59);
        drive_idle();
        check("ovf_set", {31'b0, overflow}, 32'd1);
        check("ovf_count_held", {{(32-CW){1'b0}}, fifo_count}, DEPTH);
        wait_idle("ovf_idle", 4000);
        check_stream("overflow");
        check("ovf_sticky", {31'b0, overflow}, 32'd1);

        // Host inhibit during bit 5 of F0
        model_push(1'b1, 1'b0, 8'h1C);
        drive_ev(1'b1, 1'b0, 8'h1C);
        drive_idle();
        pbase = partial_cnt;
        repeat (5) wait_fall("inh_fall", 400);
        n = 0;
        while (!ps2_clk_o && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        @(negedge CLOCK_50);
        host_clk_i = 1'b0;
        wait_cycles(3);
        check("inh_clk_high", {31'b0, ps2_clk_o}, 32'd1);
        check("inh_dat_high", {31'b0, ps2_dat_o}, 32'd1);
        lows = 0;
        repeat (40) begin
            @(negedge CLOCK_50);
            if (!ps2_clk_o || !ps2_dat_o) lows++;
        end
        check("inh_lines_held", lows, 0);
        check("inh_busy", {31'b0, busy}, 32'd1);
        host_clk_i = 1'b1;
        wait_idle("inh_idle", 2000);
        check("inh_aborted_frames", partial_cnt - pbase, 1);
        check_stream("inhibit");

        // Reset in the middle of a frame
        drive_ev(1'b0, 1'b1, 8'h11);
        drive_ev(1'b1, 1'b1, 8'h22);
        drive_ev(1'b0, 1'b0, 8'h33);
        drive_idle();
        wait_fall("rst_fall", 400);
        #2 resetn = 1'b0;
        #1;
        check("rst_clk", {31'b0, ps2_clk_o}, 32'd1);
        check("rst_dat", {31'b0, ps2_dat_o}, 32'd1);
        check("rst_count", {{(32-CW){1'b0}}, fifo_count}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_ready", {31'b0, ev_ready}, 32'd1);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        fbase = fall_cnt;
        wait_cycles(300);
        check("rst_no_frame", fall_cnt - fbase, 0);
        check("rst_rx_empty", rx_q.size(), 0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        model_push(1'b0, 1'b0, 8'h29);
        drive_ev(1'b0, 1'b0, 8'h29);
        drive_idle();
        wait_idle("after_reset_idle", 2000);
        check_stream("after_reset");

        // Randomised events against the byte-list model
        for (int k = 0; k < 15; k++) begin
            wait_cycles(int'($urandom_range(0, 150)));
            wait_ready("rnd_ready", 2000);
            rb = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            rc = 8'($urandom_range(0, 255));
            model_push(rb, re, rc);
            drive_ev(rb, re, rc);
            drive_idle();
        end
        wait_idle("rnd_idle", 12000);
        check_stream("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
